l_stf_stream_gen: RTL

Parametrised legacy short-training-field (L-STF) generator for the OFDM transmit chain. Replaces the fixed 16-entry STF lookup with a sequenced stream source. It emits the periodic 4-sample STF pattern for a programmable number of samples over a valid/ready handshake, with configurable sample width and amplitude. Optional edge windowing halves the first sample and appends a halved tail sample. It sits in front of the preamble/data multiplexer and is started once per packet by the TX controller.

---
 rtl/l_stf_pkg.sv | 21 ++
 rtl/l_stf_phase_lut.sv | 22 ++
 rtl/l_stf_stream_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/l_stf_pkg.sv
// Shared definitions for the L-STF stream generator: phase sign table,
// FSM state encoding and the negate/halve helper used by the phase LUT.
package l_stf_pkg;

  // Two bits per phase {I_neg, Q_neg}, phase 0 in the low pair.
  localparam logic [7:0] STF_SIGN_TBL = 8'b01_11_10_00;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stf_state_e;

  function automatic logic [31:0] stf_comp(input logic [31:0] amp,
                                           input logic        neg,
                                           input logic        halve);
    logic signed [31:0] v;
    v = neg ? -$signed(amp) : $signed(amp);
    return halve ? 32'(v >>> 1) : 32'(v);
  endfunction

endpackage

// File: rtl/l_stf_phase_lut.sv
// Combinational STF sample generator: maps a 2-bit phase, the amplitude and
// a halve flag to a packed {I, Q} pair.
module l_stf_phase_lut
  import l_stf_pkg::*;
#(
  parameter int              IQ_W = 16,
  parameter logic [IQ_W-1:0] AMP  = 16'h02f2
) (
  input  logic [1:0]        phase_i,
  input  logic              halve_i,
  output logic [2*IQ_W-1:0] iq_o
);

  logic [1:0] sign_s;

  assign sign_s = STF_SIGN_TBL[{phase_i, 1'b0} +: 2];

  // Width-reduce the 32-bit helper result; upper bits are pure sign extension.
  assign iq_o = {IQ_W'(stf_comp(32'(AMP), sign_s[1], halve_i)),
                 IQ_W'(stf_comp(32'(AMP), sign_s[0], halve_i))};

endmodule

// File: rtl/l_stf_stream_gen.sv
// L-STF burst source: emits NUM_SAMP (+1 tail when windowed) periodic STF
// samples over valid/ready, with abort and a done pulse after the last beat.
module l_stf_stream_gen
  import l_stf_pkg::*;
#(
  parameter int              IQ_W     = 16,
  parameter logic [IQ_W-1:0] AMP      = 16'h02f2,
  parameter int              NUM_SAMP = 160,
  parameter int              WINDOW   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [2*IQ_W-1:0] o_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              o_last,
  output logic              busy,
  output logic              done
);

  localparam int BURST_LEN = NUM_SAMP + WINDOW;
  localparam int CNT_W     = $clog2(BURST_LEN + 1);

  stf_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*IQ_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  logic              xfer_s;
  logic              load_s;
  logic [CNT_W-1:0]  idx_s;
  logic              is_tail_s;
  logic [1:0]        phase_s;
  logic              halve_s;
  logic [2*IQ_W-1:0] lut_iq_s;

  assign xfer_s = valid_q & o_ready;

  // Index of the sample to be loaded next: 0 when entering RUN, else cnt+1.
  assign idx_s     = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
  assign is_tail_s = (WINDOW != 0) && (idx_s == CNT_W'(NUM_SAMP));
  assign phase_s   = is_tail_s ? 2'd0 : idx_s[1:0];
  assign halve_s   = (WINDOW != 0) && ((idx_s == '0) || is_tail_s);

  l_stf_phase_lut #(
    .IQ_W (IQ_W),
    .AMP  (AMP)
  ) u_lut (
    .phase_i (phase_s),
    .halve_i (halve_s),
    .iq_o    (lut_iq_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          valid_d = 1'b1;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // abort outranks a same-cycle transfer: the offered beat is dropped
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else if (xfer_s && last_q) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end else if (xfer_s) begin
          cnt_d  = cnt_q + CNT_W'(1);
          load_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    if (load_s) begin
      data_d = lut_iq_s;
      last_d = (idx_s == CNT_W'(BURST_LEN - 1));
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign busy    = (state_q == RUN);
  assign done    = done_q;

endmodule
